t03_mem_arbiter: RTL and testbench

- Sequences the single shared memory port between the instruction fetch path and the data load/store path.
- Drives the freeze control of the instruction holder, so the fetched instruction stays stable while a data access for that instruction is in flight.
- Produces the CPU-wide stall signal.
- Sits between the fetch/execute logic and the memory-side bus interface.

---
 rtl/t03_mem_arbiter.sv | 132 +++++++++++++
 tb/tb_t03_mem_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/t03_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : t03_mem_arbiter
// Purpose  : Shares one memory port between instruction fetch and data
//            load/store; drives instruction-holder freeze and CPU stall.
// Revision : 1.0 - initial release
// ============================================================================
module t03_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_ack,
  input  logic                d_read,
  input  logic                d_write,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_sel,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ack,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_sel,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,
  output logic                freeze_instr,
  output logic                cpu_stall,
  output logic                timeout_err
);

  localparam int c_CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               r_state;
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 w_dreq;

  assign w_dreq = d_read | d_write;

  // d_ack is only ever high in DONE, so it marks a completing data access
  assign freeze_instr = ((r_state == IDLE) && w_dreq) || (r_state == DATA) ||
                        ((r_state == DONE) && d_ack);
  assign cpu_stall    = (i_req & ~i_ack) | (w_dreq & ~d_ack);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      i_rdata     <= '0;
      d_rdata     <= '0;
      i_ack       <= 1'b0;
      d_ack       <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_sel     <= '0;
      timeout_err <= 1'b0;
    end else begin
      i_ack       <= 1'b0;
      d_ack       <= 1'b0;
      timeout_err <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_dreq) begin
            r_state   <= DATA;
            mem_req   <= 1'b1;
            mem_we    <= d_write;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_sel   <= d_sel;
          end else if (i_req) begin
            r_state  <= FETCH;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= i_addr;
            mem_sel  <= '1;
          end
        end
        FETCH, DATA: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            r_state <= DONE;
            if (r_state == FETCH) begin
              i_ack   <= 1'b1;
              i_rdata <= mem_rdata;
            end else begin
              d_ack <= 1'b1;
              if (!mem_we) d_rdata <= mem_rdata;
            end
          end else if (r_cnt == c_CNT_MAX) begin
            // abort: complete with zero data and flag the error alongside the ack
            mem_req     <= 1'b0;
            r_state     <= DONE;
            timeout_err <= 1'b1;
            if (r_state == FETCH) begin
              i_ack   <= 1'b1;
              i_rdata <= '0;
            end else begin
              d_ack <= 1'b1;
              if (!mem_we) d_rdata <= '0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          r_cnt   <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_t03_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_t03_mem_arbiter
// Purpose  : Directed plus randomized transaction checks of t03_mem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_t03_mem_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        nrst;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_sel;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_sel;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        freeze_instr;
  logic        cpu_stall;
  logic        timeout_err;

  int n_checks = 0;
  int n_fails  = 0;

  logic [31:0] m_irdata;
  logic [31:0] m_drdata;

  t03_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .nrst(nrst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_sel(d_sel), .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_sel(mem_sel), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .freeze_instr(freeze_instr), .cpu_stall(cpu_stall),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // kind: 0 fetch, 1 read, 2 write, 3 write+read. lat = mem_req cycle in which
  // mem_ack is given; lat > TO means memory never answers.
  task automatic txn(input int kind, input bit hold_i, input bit withdraw,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] sel, input int lat, input logic [31:0] rdata);
    bit is_data, is_wr, tmo;
    int nreq;
    is_data = (kind != 0);
    is_wr   = (kind >= 2);
    tmo     = (lat > TO);
    nreq    = tmo ? TO : lat;
    if (is_data) begin
      i_req   = hold_i;
      i_addr  = $urandom;
      d_read  = (kind == 1) || (kind == 3);
      d_write = is_wr;
      d_addr  = addr;
      d_wdata = wdata;
      d_sel   = sel;
    end else begin
      i_req   = 1'b1;
      i_addr  = addr;
      d_read  = 1'b0;
      d_write = 1'b0;
      d_addr  = $urandom;
      d_wdata = $urandom;
      d_sel   = 4'($urandom);
    end
    #1;
    chk1("freeze_req_cycle", freeze_instr, is_data);
    chk1("stall_req_cycle", cpu_stall, 1'b1);
    for (int c = 1; c <= nreq; c++) begin
      tick();
      chk1("mem_req_held", mem_req, 1'b1);
      chk1("mem_we", mem_we, is_wr);
      chk("mem_addr", mem_addr, addr);
      chk("mem_sel", 32'(mem_sel), is_data ? 32'(sel) : 32'hF);
      if (is_wr) chk("mem_wdata", mem_wdata, wdata);
      chk1("ack_early", i_ack | d_ack, 1'b0);
      if (withdraw) begin
        d_read  = 1'b0;
        d_write = 1'b0;
      end
      // requester inputs move freely once the access is granted
      i_addr    = $urandom;
      d_addr    = $urandom;
      d_wdata   = $urandom;
      d_sel     = 4'($urandom);
      mem_ack   = (!tmo && c == lat);
      mem_rdata = (c == lat) ? rdata : $urandom;
      #1;
      chk1("freeze_busy", freeze_instr, is_data);
    end
    tick();
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
    #1;
    if (!is_data) m_irdata = tmo ? 32'h0 : rdata;
    else if (!is_wr) m_drdata = tmo ? 32'h0 : rdata;
    chk1("mem_req_done", mem_req, 1'b0);
    chk1("i_ack_done", i_ack, !is_data);
    chk1("d_ack_done", d_ack, is_data);
    chk1("timeout_err", timeout_err, tmo);
    chk("i_rdata", i_rdata, m_irdata);
    chk("d_rdata", d_rdata, m_drdata);
    chk1("freeze_done", freeze_instr, is_data);
    chk1("stall_done", cpu_stall, (i_req && is_data) || ((d_read || d_write) && !is_data));
    d_read  = 1'b0;
    d_write = 1'b0;
    i_req   = hold_i && is_data;
    tick();
    chk1("ack_cleared", i_ack | d_ack, 1'b0);
    chk1("tmo_cleared", timeout_err, 1'b0);
    chk1("idle_no_req", mem_req, 1'b0);
  endtask

  initial begin
    m_irdata  = 32'h0;
    m_drdata  = 32'h0;
    nrst      = 1'b0;
    i_req     = 1'b0;
    i_addr    = 32'h0;
    d_read    = 1'b0;
    d_write   = 1'b0;
    d_addr    = 32'h0;
    d_wdata   = 32'h0;
    d_sel     = 4'h0;
    mem_rdata = 32'h0;
    mem_ack   = 1'b0;
    tick();
    tick();
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_acks", i_ack | d_ack, 1'b0);
    chk("rst_i_rdata", i_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk1("rst_tmo", timeout_err, 1'b0);
    nrst = 1'b1;
    tick();

    // reset in the middle of a data access
    d_read = 1'b1;
    d_addr = 32'h200;
    tick();
    chk1("pre_rst_mem_req", mem_req, 1'b1);
    d_read = 1'b0;
    nrst   = 1'b0;
    #1;
    chk1("async_rst_mem_req", mem_req, 1'b0);
    chk("async_rst_mem_addr", mem_addr, 32'h0);
    chk1("async_rst_freeze", freeze_instr, 1'b0);
    tick();
    nrst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk1("post_rst_no_ack", d_ack | i_ack, 1'b0);
      chk1("post_rst_idle", mem_req, 1'b0);
    end

    // plain fetch, acknowledged in the first request cycle
    txn(0, 1'b0, 1'b0, 32'h0000_0040, 32'h0, 4'h0, 1, 32'h0051_0113);
    // fetch and load together: load first, fetch behind it
    txn(1, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'hF, 3, 32'hCAFE_F00D);
    txn(0, 1'b0, 1'b0, 32'h0000_0044, 32'h0, 4'h0, 2, 32'h0000_0013);
    // write and read together: write wins, d_rdata untouched
    txn(3, 1'b0, 1'b0, 32'h0000_0180, 32'h1234_5678, 4'b0011, 2, 32'hDEAD_BEEF);
    // memory never answers
    txn(1, 1'b0, 1'b0, 32'h0000_0300, 32'h0, 4'hF, TO + 5, 32'h5555_AAAA);
    // ack arriving in the very last allowed cycle still counts
    txn(1, 1'b0, 1'b0, 32'h0000_0304, 32'h0, 4'hF, TO, 32'h7777_1111);
    // fetch timeout
    txn(0, 1'b0, 1'b0, 32'h0000_0048, 32'h0, 4'h0, TO + 1, 32'h9999_9999);

    // spurious ack while idle
    mem_ack   = 1'b1;
    mem_rdata = 32'hBAD0_BAD0;
    tick();
    mem_ack = 1'b0;
    chk1("spurious_no_ack", i_ack | d_ack, 1'b0);
    chk1("spurious_no_req", mem_req, 1'b0);
    chk("spurious_d_rdata", d_rdata, m_drdata);
    tick();
    chk1("spurious_no_ack2", i_ack | d_ack, 1'b0);
    // withdrawn load still completes
    txn(1, 1'b0, 1'b1, 32'h0000_0400, 32'h0, 4'hF, 2, 32'h0BAD_F00D);

    for (int n = 0; n < 40; n++) begin
      int k;
      int l;
      k = int'($urandom_range(0, 3));
      l = (k >= 2) ? int'($urandom_range(1, TO)) : int'($urandom_range(1, TO + 2));
      txn(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)) && (k != 0),
          $urandom, $urandom, 4'($urandom), l, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
